// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
// The slave modport is the decode stage; the master drives fetch-side inputs and out_ready.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic            out_funct7_b5;
  logic [XLEN-1:0] out_imm;
  logic [9:0]      out_c_bus;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_funct3, out_funct7_b5, out_imm, out_c_bus, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_funct3, out_funct7_b5, out_imm, out_c_bus, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational decode captured into an output register,
// backed by a skid register so a single stall never bubbles the input side.
module decode_stage #(
  parameter int XLEN         = 32,
  parameter bit ALLOW_SYSTEM = 1'b1
) (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);
  // state | meaning
  // EMPTY | OUT and SKID empty; out_valid=0, in_ready=1
  // ONE   | OUT holds a bundle, SKID empty; out_valid=1, in_ready=1
  // FULL  | OUT and SKID both hold bundles; out_valid=1, in_ready=0
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic [XLEN-1:0] imm;
    logic [9:0]      c_bus;
    logic            illegal;
  } bundle_t;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_ARITH_I = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_ARITH   = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam int CB_PC_SRC    = 0;
  localparam int CB_MEM_WE    = 1;
  localparam int CB_ALU_A_PC  = 2;
  localparam int CB_ALU_B_IMM = 3;
  localparam int CB_WB_EN     = 4;
  localparam int CB_WB_SRC_LO = 5;
  localparam int CB_WB_SRC_HI = 6;
  localparam int CB_MEM_RE    = 7;
  localparam int CB_IS_BRANCH = 8;
  localparam int CB_IS_JALR   = 9;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_PC4  = 2'b01;
  localparam logic [1:0] WB_DMEM = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  logic [31:0]     w_inst;
  logic [6:0]      w_opc;
  logic            w_rd_nz;
  logic [31:0]     w_imm_i;
  logic [31:0]     w_imm_s;
  logic [31:0]     w_imm_b;
  logic [31:0]     w_imm_u;
  logic [31:0]     w_imm_j;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm_ext;
  logic [9:0]      w_c_bus;
  logic            w_illegal;
  bundle_t         w_dec;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_in_ready;
  logic            r_out_valid;
  bundle_t         r_out;
  bundle_t         r_skid;
  logic            w_accept;
  logic            w_load_out;
  logic            w_load_skid;
  logic            w_skid_to_out;

  assign w_inst  = bus.in_inst;
  assign w_opc   = w_inst[6:0];
  assign w_rd_nz = |w_inst[11:7];

  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'b0};
  assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  // Illegal encodings fall through with immediate and control bus left at zero.
  always_comb begin
    w_imm32   = '0;
    w_c_bus   = '0;
    w_illegal = 1'b0;
    if (w_inst[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_opc)
        OPC_LOAD: begin
          w_imm32                             = w_imm_i;
          w_c_bus[CB_ALU_B_IMM]               = 1'b1;
          w_c_bus[CB_WB_EN]                   = w_rd_nz;
          w_c_bus[CB_WB_SRC_HI:CB_WB_SRC_LO]  = WB_DMEM;
          w_c_bus[CB_MEM_RE]                  = 1'b1;
        end
        OPC_STORE: begin
          w_imm32                             = w_imm_s;
          w_c_bus[CB_MEM_WE]                  = 1'b1;
          w_c_bus[CB_ALU_B_IMM]               = 1'b1;
        end
        OPC_BRANCH: begin
          w_imm32                             = w_imm_b;
          w_c_bus[CB_PC_SRC]                  = 1'b1;
          w_c_bus[CB_IS_BRANCH]               = 1'b1;
        end
        OPC_JALR: begin
          w_imm32                             = w_imm_i;
          w_c_bus[CB_PC_SRC]                  = 1'b1;
          w_c_bus[CB_ALU_A_PC]                = 1'b1;
          w_c_bus[CB_WB_EN]                   = w_rd_nz;
          w_c_bus[CB_WB_SRC_HI:CB_WB_SRC_LO]  = WB_PC4;
          w_c_bus[CB_IS_JALR]                 = 1'b1;
        end
        OPC_JAL: begin
          w_imm32                             = w_imm_j;
          w_c_bus[CB_PC_SRC]                  = 1'b1;
          w_c_bus[CB_ALU_A_PC]                = 1'b1;
          w_c_bus[CB_WB_EN]                   = w_rd_nz;
          w_c_bus[CB_WB_SRC_HI:CB_WB_SRC_LO]  = WB_PC4;
        end
        OPC_ARITH_I: begin
          w_imm32                             = w_imm_i;
          w_c_bus[CB_ALU_B_IMM]               = 1'b1;
          w_c_bus[CB_WB_EN]                   = w_rd_nz;
          w_c_bus[CB_WB_SRC_HI:CB_WB_SRC_LO]  = WB_ALU;
        end
        OPC_ARITH: begin
          w_c_bus[CB_WB_EN]                   = w_rd_nz;
          w_c_bus[CB_WB_SRC_HI:CB_WB_SRC_LO]  = WB_ALU;
        end
        OPC_LUI: begin
          w_imm32                             = w_imm_u;
          w_c_bus[CB_WB_EN]                   = w_rd_nz;
          w_c_bus[CB_WB_SRC_HI:CB_WB_SRC_LO]  = WB_IMM;
        end
        OPC_AUIPC: begin
          w_imm32                             = w_imm_u;
          w_c_bus[CB_ALU_A_PC]                = 1'b1;
          w_c_bus[CB_ALU_B_IMM]               = 1'b1;
          w_c_bus[CB_WB_EN]                   = w_rd_nz;
          w_c_bus[CB_WB_SRC_HI:CB_WB_SRC_LO]  = WB_ALU;
        end
        OPC_FENCE, OPC_SYSTEM: begin
          w_illegal = !ALLOW_SYSTEM;
        end
        default: begin
          w_illegal = 1'b1;
        end
      endcase
    end
  end

  generate
    if (XLEN > 32) begin : g_imm_wide
      assign w_imm_ext = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_narrow
      assign w_imm_ext = w_imm32[XLEN-1:0];
    end
  endgenerate

  always_comb begin
    w_dec           = '0;
    w_dec.pc        = bus.in_pc;
    w_dec.rs1       = w_inst[19:15];
    w_dec.rs2       = w_inst[24:20];
    w_dec.rd        = w_inst[11:7];
    w_dec.funct3    = w_inst[14:12];
    w_dec.funct7_b5 = w_inst[30];
    w_dec.imm       = w_imm_ext;
    w_dec.c_bus     = w_c_bus;
    w_dec.illegal   = w_illegal;
  end

  // Flush wins over any transfer, so the acceptance term excludes it up front.
  assign w_accept = bus.in_valid && r_in_ready && !bus.flush;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = S_ONE;
            w_load_out  = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && bus.out_ready) begin
            w_load_out  = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = S_FULL;
            w_load_skid = 1'b1;
          end else if (bus.out_ready) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (bus.out_ready) begin
            w_state_nxt   = S_ONE;
            w_skid_to_out = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // r_in_ready mirrors "SKID empty" and r_out_valid mirrors "OUT valid", both
  // registered so neither has a combinational path from out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (w_load_out) begin
        r_out <= w_dec;
      end else if (w_skid_to_out) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_pc        = r_out.pc;
  assign bus.out_rs1       = r_out.rs1;
  assign bus.out_rs2       = r_out.rs2;
  assign bus.out_rd        = r_out.rd;
  assign bus.out_funct3    = r_out.funct3;
  assign bus.out_funct7_b5 = r_out.funct7_b5;
  assign bus.out_imm       = r_out.imm;
  assign bus.out_c_bus     = r_out.c_bus;
  assign bus.out_illegal   = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table streamed through a scoreboard, plus hand-written
// backpressure, flush, async-reset and 64-bit sequences.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) b32 ();
  decode_stage_if #(.XLEN(64)) b64 ();

  decode_stage #(.XLEN(32), .ALLOW_SYSTEM(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  decode_stage #(.XLEN(64), .ALLOW_SYSTEM(1'b0)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [9:0]  cbus;
    logic        ill;
    logic [4:0]  rd;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [63:0] imm;
    logic [9:0]  cbus;
    logic        ill;
    logic [4:0]  rd;
  } exp_t;

  localparam int NVEC = 14;
  vec_t vt [NVEC];
  exp_t sb [$];
  int   total;
  int   bad;
  int   n_emit;

  function automatic logic [31:0] pc_of(input int i);
    return 32'h0000_1000 + 32'(i * 4);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int idx);
    b32.in_valid = v;
    b32.in_inst  = vt[idx].inst;
    b32.in_pc    = pc_of(idx);
  endtask

  // One clock of the 32-bit DUT: score the output transfer, record the input transfer,
  // then advance to just after the next rising edge.
  task automatic cycle(input int idx, output bit acc);
    bit   emit;
    exp_t e;
    acc  = !rst && b32.in_valid && b32.in_ready && !b32.flush;
    emit = !rst && b32.out_valid && b32.out_ready && !b32.flush;
    if (emit) begin
      n_emit++;
      if (sb.size() == 0) begin
        check("unexpected emission", 64'(b32.out_pc), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d pc", e.idx), 64'(b32.out_pc), 64'(e.pc));
        check($sformatf("v%0d rd", e.idx), 64'(b32.out_rd), 64'(e.rd));
        check($sformatf("v%0d imm", e.idx), 64'(b32.out_imm), e.imm);
        check($sformatf("v%0d c_bus", e.idx), 64'(b32.out_c_bus), 64'(e.cbus));
        check($sformatf("v%0d illegal", e.idx), 64'(b32.out_illegal), 64'(e.ill));
      end
    end
    if (b32.flush) sb.delete();
    if (acc) begin
      e.idx  = idx;
      e.pc   = pc_of(idx);
      e.imm  = vt[idx].imm;
      e.cbus = vt[idx].cbus;
      e.ill  = vt[idx].ill;
      e.rd   = vt[idx].rd;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    int b;
    b = 0;
    b32.out_ready = 1'b1;
    drive(1'b0, 0);
    while (sb.size() != 0 && b < 20) begin
      cycle(0, acc);
      b++;
    end
    check("drain queue empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k;
    int c;
    int last;
    int ncyc;
    int e0;

    total  = 0;
    bad    = 0;
    n_emit = 0;
    vt[0]  = '{32'hFFF00093, 64'hFFFF_FFFF, 10'h018, 1'b0, 5'd1};   // ADDI x1,x0,-1
    vt[1]  = '{32'hFFDFF0EF, 64'hFFFF_FFFC, 10'h035, 1'b0, 5'd1};   // JAL x1,-4
    vt[2]  = '{32'h123452B7, 64'h1234_5000, 10'h070, 1'b0, 5'd5};   // LUI x5,0x12345
    vt[3]  = '{32'h0020A423, 64'h0000_0008, 10'h00A, 1'b0, 5'd8};   // SW x2,8(x1)
    vt[4]  = '{32'h00208033, 64'h0000_0000, 10'h000, 1'b0, 5'd0};   // ADD x0,x1,x2
    vt[5]  = '{32'h00000000, 64'h0000_0000, 10'h000, 1'b1, 5'd0};   // all zero
    vt[6]  = '{32'h00001197, 64'h0000_1000, 10'h01C, 1'b0, 5'd3};   // AUIPC x3,1
    vt[7]  = '{32'h00408067, 64'h0000_0004, 10'h225, 1'b0, 5'd0};   // JALR x0,4(x1)
    vt[8]  = '{32'hFE000EE3, 64'hFFFF_FFFC, 10'h101, 1'b0, 5'd29};  // BEQ x0,x0,-4
    vt[9]  = '{32'hFF012383, 64'hFFFF_FFF0, 10'h0D8, 1'b0, 5'd7};   // LW x7,-16(x2)
    vt[10] = '{32'h0000000F, 64'h0000_0000, 10'h000, 1'b0, 5'd0};   // FENCE
    vt[11] = '{32'h00000073, 64'h0000_0000, 10'h000, 1'b0, 5'd0};   // ECALL
    vt[12] = '{32'hFFF00090, 64'h0000_0000, 10'h000, 1'b1, 5'd1};   // ADDI with bad low bits
    vt[13] = '{32'h0000007F, 64'h0000_0000, 10'h000, 1'b1, 5'd0};   // unknown opcode

    rst = 1'b1;
    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_pc = '0; b32.out_ready = 1'b1;
    b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_pc = '0; b64.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst out_valid", 64'(b32.out_valid), 64'd0);
    check("rst in_ready", 64'(b32.in_ready), 64'd1);
    check("rst out_imm", 64'(b32.out_imm), 64'd0);
    check("rst out_c_bus", 64'(b32.out_c_bus), 64'd0);
    check("rst64 out_valid", 64'(b64.out_valid), 64'd0);
    check("rst64 in_ready", 64'(b64.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Full-rate stream of the whole table.
    drive(1'b1, 0);
    cycle(0, acc);
    check("first accept", 64'(acc), 64'd1);
    check("latency out_valid", 64'(b32.out_valid), 64'd1);
    k = 1;
    ncyc = 0;
    while (k < NVEC && ncyc < 40) begin
      drive(1'b1, k);
      cycle(k, acc);
      ncyc++;
      if (acc) k++;
    end
    check("stream cycles", 64'(ncyc), 64'(NVEC - 1));
    drain();

    // Backpressure: out_ready low in cycles 2..4.
    e0 = n_emit;
    k = 1;
    c = 0;
    last = 0;
    while ((k < 5 || sb.size() != 0) && c < 30) begin
      c++;
      b32.out_ready = !(c >= 2 && c <= 4);
      if (k < 5) drive(1'b1, k);
      else drive(1'b0, 0);
      cycle((k < 5) ? k : 0, acc);
      if (acc) begin
        last = c;
        k++;
      end
      if (c == 2) begin
        check("bp in_ready after two accepts", 64'(b32.in_ready), 64'd0);
        check("bp out_valid held", 64'(b32.out_valid), 64'd1);
      end
    end
    check("bp last accept cycle", 64'(last), 64'd7);
    check("bp emitted count", 64'(n_emit - e0), 64'd4);

    // Flush while FULL with a third instruction presented.
    e0 = n_emit;
    b32.out_ready = 1'b0;
    drive(1'b1, 6);
    cycle(6, acc);
    drive(1'b1, 7);
    cycle(7, acc);
    check("flush pre in_ready", 64'(b32.in_ready), 64'd0);
    drive(1'b1, 8);
    b32.flush = 1'b1;
    cycle(8, acc);
    b32.flush = 1'b0;
    drive(1'b0, 0);
    check("flush out_valid", 64'(b32.out_valid), 64'd0);
    check("flush in_ready", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    repeat (4) cycle(0, acc);
    check("flush nothing emitted", 64'(n_emit - e0), 64'd0);
    drive(1'b1, 9);
    cycle(9, acc);
    drain();

    // Asynchronous reset between edges while FULL.
    b32.out_ready = 1'b0;
    drive(1'b1, 10);
    cycle(10, acc);
    drive(1'b1, 11);
    cycle(11, acc);
    check("pre-rst out_valid", 64'(b32.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst out_valid", 64'(b32.out_valid), 64'd0);
    check("async rst in_ready", 64'(b32.in_ready), 64'd1);
    check("async rst out_pc", 64'(b32.out_pc), 64'd0);
    sb.delete();
    drive(1'b0, 0);
    b32.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2);
    cycle(2, acc);
    drain();

    // 64-bit instance with FENCE/SYSTEM disallowed.
    @(negedge clk);
    b64.in_valid = 1'b1;
    b64.in_inst  = 32'hFFF00093;
    b64.in_pc    = 64'h8000_0000_0000_0000;
    @(posedge clk);
    #1;
    b64.in_inst  = 32'h800002B7;   // LUI x5,0x80000
    b64.in_pc    = 64'h8000_0000_0000_0004;
    check("x64 addi out_valid", 64'(b64.out_valid), 64'd1);
    check("x64 addi imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("x64 addi c_bus", 64'(b64.out_c_bus), 64'h018);
    check("x64 addi pc", b64.out_pc, 64'h8000_0000_0000_0000);
    @(posedge clk);
    #1;
    b64.in_inst  = 32'h0000000F;
    check("x64 lui imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
    check("x64 lui c_bus", 64'(b64.out_c_bus), 64'h070);
    @(posedge clk);
    #1;
    b64.in_valid = 1'b0;
    check("x64 fence illegal", 64'(b64.out_illegal), 64'd1);
    check("x64 fence c_bus", 64'(b64.out_c_bus), 64'd0);
    @(posedge clk);
    #1;
    check("x64 idle out_valid", 64'(b64.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
